// File: rtl/adder_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : adder_arbiter_if
//  Description : Request/response and shared-adder operand bundle for
//                adder_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface adder_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [3:0]         req_valid;
    logic [4*WIDTH-1:0] req_x;
    logic [4*WIDTH-1:0] req_y;
    logic [3:0]         req_ready;
    logic [WIDTH-1:0]   add_x;
    logic [WIDTH-1:0]   add_y;
    logic [WIDTH-1:0]   add_out;
    logic [3:0]         rsp_valid;
    logic [WIDTH-1:0]   rsp_data;
    logic [1:0]         rsp_id;
    logic               busy;

    // Scheduler side.
    modport slave (
        input  req_valid, req_x, req_y, add_out,
        output req_ready, add_x, add_y, rsp_valid, rsp_data, rsp_id, busy
    );

    // Requesters plus the shared adder.
    modport master (
        output req_valid, req_x, req_y, add_out,
        input  req_ready, add_x, add_y, rsp_valid, rsp_data, rsp_id, busy
    );
endinterface
`default_nettype wire

// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : adder_arbiter
//  Description : Round-robin scheduler sharing one multi-cycle adder between
//                four requesters; returns tagged one-cycle responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_arbiter #(
    parameter int WIDTH      = 32,
    parameter int WAIT_CONST = 0
) (
    input  wire logic      clk,
    input  wire logic      rst,
    adder_arbiter_if.slave bus
);

    // Holding for WAIT_CONST+2 edges covers one full adder sampling period
    // whatever its phase relative to the handshake.
    localparam logic [2:0] c_CAPTURE = 3'(WAIT_CONST + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t           r_state;
    logic [1:0]       r_ptr;
    logic [2:0]       r_cnt;
    logic [WIDTH-1:0] r_add_x;
    logic [WIDTH-1:0] r_add_y;
    logic [3:0]       r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic [1:0]       r_rsp_id;

    logic [1:0]       w_idx;
    logic [1:0]       w_win;
    logic             w_any;
    logic [3:0]       w_grant;
    logic [WIDTH-1:0] w_sel_x;
    logic [WIDTH-1:0] w_sel_y;

    // Scan from the farthest offset down so the nearest one after ptr wins.
    always_comb begin
        w_idx = r_ptr;
        w_win = r_ptr;
        w_any = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            w_idx = r_ptr + 2'(i);
            if (bus.req_valid[w_idx]) begin
                w_win = w_idx;
                w_any = 1'b1;
            end
        end
    end

    always_comb begin
        w_grant = 4'b0000;
        if (w_any && (r_state == S_IDLE)) begin
            w_grant = 4'b0001 << w_win;
        end
    end

    always_comb begin
        w_sel_x = bus.req_x[0 +: WIDTH];
        w_sel_y = bus.req_y[0 +: WIDTH];
        case (w_win)
            2'd1: begin
                w_sel_x = bus.req_x[WIDTH +: WIDTH];
                w_sel_y = bus.req_y[WIDTH +: WIDTH];
            end
            2'd2: begin
                w_sel_x = bus.req_x[2*WIDTH +: WIDTH];
                w_sel_y = bus.req_y[2*WIDTH +: WIDTH];
            end
            2'd3: begin
                w_sel_x = bus.req_x[3*WIDTH +: WIDTH];
                w_sel_y = bus.req_y[3*WIDTH +: WIDTH];
            end
            default: begin
                w_sel_x = bus.req_x[0 +: WIDTH];
                w_sel_y = bus.req_y[0 +: WIDTH];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= 2'd0;
            r_cnt       <= 3'd0;
            r_add_x     <= '0;
            r_add_y     <= '0;
            r_rsp_valid <= 4'b0000;
            r_rsp_data  <= '0;
            r_rsp_id    <= 2'd0;
        end else begin
            r_rsp_valid <= 4'b0000;
            case (r_state)
                S_IDLE: begin
                    if (|w_grant) begin
                        r_add_x  <= w_sel_x;
                        r_add_y  <= w_sel_y;
                        r_rsp_id <= w_win;
                        r_ptr    <= w_win + 2'd1;
                        r_cnt    <= 3'd0;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == c_CAPTURE) begin
                        r_rsp_data  <= bus.add_out;
                        r_rsp_valid <= 4'b0001 << r_rsp_id;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.add_x     = r_add_x;
    assign bus.add_y     = r_add_y;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.busy      = (r_state == S_WAIT);

endmodule
`default_nettype wire

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin scheduler that shares one multi-cycle `adder` instance (parameters `WIDTH`, `WAIT_CONST`) between four requesters. It accepts one add request at a time over a valid/ready handshake and drives the adder's operand inputs. It holds those operands for the adder's worst-case sampling window, captures the sum, and returns it as a one-cycle response tagged with the requester id. It sits between the CPU's functional-unit clients (address generation, PC increment, ALU issue, debug) and the single shared adder.

## Interface
- `WIDTH`, 32: operand and result width; must match the adder's `WIDTH`.
- `WAIT_CONST`, 0: the adder's `WAIT_CONST`; legal range 0..3, because the adder's wait counter is 2 bits.
- `clk`  input  1  rising-edge clock, shared with the adder.
- `rst`  input  1  synchronous, active-high reset.
- `req_valid`  input  4  per-requester request strobe; bit i belongs to requester i.
- `req_x`  input  4*WIDTH  operand x; requester i uses bits [i*WIDTH +: WIDTH].
- `req_y`  input  4*WIDTH  operand y, same packing as `req_x`.
- `req_ready`  output  4  one-hot grant; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `add_x`  output  WIDTH  registered operand x, driven to the adder's `x`.
- `add_y`  output  WIDTH  registered operand y, driven to the adder's `y`.
- `add_out`  input  WIDTH  the adder's `out`.
- `rsp_valid`  output  4  one-hot, one-cycle result strobe.
- `rsp_data`  output  WIDTH  captured sum; valid while any `rsp_valid` bit is high.
- `rsp_id`  output  2  index of the requester that owns `rsp_data`.
- `busy`  output  1  high while an operation is in flight (state WAIT).

## Operation
- States:
  - IDLE: arbitrate among pending requests.
  - WAIT: hold the operands and count cycles.
- Reset values: state IDLE, round-robin pointer `ptr`=0, `add_x`=0, `add_y`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, wait counter `cnt`=0. `req_ready` and `busy` are 0 because they decode from the IDLE state.
- Arbitration in IDLE is combinational. The winner is the first set bit of `req_valid` scanning `ptr`, `ptr`+1, … mod 4. `req_ready` is one-hot on the winner; it is all-zero if `req_valid`==0 or the state is WAIT.
- On a handshake edge:
  - `add_x`/`add_y` load the winner's operands.
  - `rsp_id` loads the winner index.
  - `ptr` becomes winner+1 mod 4.
  - `cnt` becomes 0 and the state goes to WAIT.
- In WAIT, `cnt` increments each edge. On the edge where `cnt`==WAIT_CONST+1:
  - `rsp_data` loads `add_out`.
  - `rsp_valid` goes one-hot on `rsp_id`.
  - The state returns to IDLE.
- Why WAIT_CONST+1: the adder samples on a free-running period of WAIT_CONST+1 edges. Holding the operands for WAIT_CONST+2 edges guarantees `add_out` reflects them regardless of phase.
- `rsp_valid` is high for exactly one cycle, then clears.
- `add_x`/`add_y` hold their last values between operations; they change only at a handshake.
- Arithmetic is the adder's: modulo 2^WIDTH, no carry-out, no overflow flag.
- A requester may drop `req_valid` before it is granted. No operation starts and `ptr` does not move.
- Operands must be stable only in the handshake cycle.
- Reset during WAIT abandons the operation: no response is produced and `ptr` returns to 0.

## Timing
- Call the handshake edge E0. The capture edge is E(WAIT_CONST+2), and `rsp_valid` is high in the cycle after it. Latency is WAIT_CONST+2 cycles.
- The state is IDLE in the `rsp_valid` cycle, so a new grant may be given in that same cycle. The next handshake edge is E(WAIT_CONST+3), giving a throughput of one op per WAIT_CONST+3 cycles.
- With WAIT_CONST=0, `busy` is high for 2 cycles per op.
- Simultaneous requests are resolved strictly by `ptr`; no requester waits more than 3 grants.
- A request arriving during WAIT is not acknowledged until IDLE.
- `req_ready` may depend combinationally on `req_valid`. `req_valid` must not depend combinationally on `req_ready`.

## Test plan
- Reset with WAIT_CONST=0. Hold `rst` 2 cycles, then release → all outputs 0; `req_ready`=0 with no requests.
- Single request, WAIT_CONST=0: requester 2 asserts x=5, y=7 → handshake at E0. Then `rsp_valid`=4'b0100, `rsp_data`=12, `rsp_id`=2, exactly 2 cycles later, for 1 cycle.
- Wrap-around, WAIT_CONST=3, WIDTH=32: requester 0 sends x=32'hFFFF_FFFF, y=2 → `rsp_data`=1 after 5 cycles; `busy` high 5 cycles.
- Fairness: all four `req_valid` held high continuously with distinct operands → grant order 0,1,2,3,0. Handshakes are spaced WAIT_CONST+3 cycles apart and each `rsp_data` matches its requester's sum.
- Phase independence, WAIT_CONST=2: issue requests starting at each of 3 successive adder-counter phases → the correct sum is returned every time.
- Reset mid-operation: assert `rst` in cycle 1 of WAIT → no `rsp_valid` pulse. The next request from requester 3 (with requesters 0 and 3 pending) is granted to requester 0, showing `ptr`=0.
